// File: rtl/sub_nibbles.sv
// Nibble-substitution stage: per-nibble 4-bit S-box (forward or inverse, chosen per word)
// feeding a 2-entry skid buffer with valid/ready handshakes on both sides.
module sub_nibbles #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             dir_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data_in_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_out_o,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam int NIB = WIDTH / 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    logic [WIDTH-1:0] sub_word;

    // Substitute before storage so buffered entries carry their own direction.
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        assign sub_word[gi*4 +: 4] = dir_i ? sbox_inv(data_in_i[gi*4 +: 4])
                                           : sbox_fwd(data_in_i[gi*4 +: 4]);
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, deliver;

    assign out_valid_o = (state_q != EMPTY);
    assign in_ready_o  = in_ready_q;
    assign data_out_o  = main_q;
    assign word_cnt_o  = cnt_q;

    assign accept  = in_valid_i & in_ready_q;
    assign deliver = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = sub_word;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    main_d = sub_word;
                end else if (accept) begin
                    skid_d  = sub_word;
                    state_d = TWO;
                end else if (deliver) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (deliver) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Registered ready: derived from next state, never from out_ready in the same cycle.
        in_ready_d = (state_d != TWO);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (deliver) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
